chien_search_stage: RTL

//  Final stage of the GF(2^4) BCH(15,7) t=2 decoder, directly downstream of BM stage 3.

---
 rtl/bch_pkg.sv | 35 +++
 rtl/gf_mul_const.sv | 15 +
 rtl/chien_search_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bch_pkg.sv
// Shared GF(16) types, constants and constant-multiply helper for the BCH(15,7) decoder.
// Primitive polynomial x^4+x+1.
package bch_pkg;

    localparam int N = 15;

    typedef logic [3:0] gf_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } chien_state_t;

    localparam gf_t ALPHA_INV  = 4'b1001;
    localparam gf_t ALPHA_INV2 = 4'b1101;

    function automatic gf_t gf_xtime(gf_t a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'b0011 : 4'b0000);
    endfunction

    // With c constant this folds down to a fixed XOR network.
    function automatic gf_t gf_mul_c(gf_t a, gf_t c);
        gf_t p;
        gf_t y;
        p = a;
        y = '0;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) y = y ^ p;
            p = gf_xtime(p);
        end
        return y;
    endfunction

endpackage

// File: rtl/gf_mul_const.sv
// Combinational GF(16) multiply by a fixed field constant C.
module gf_mul_const
    import bch_pkg::*;
#(
    parameter gf_t C = 4'b0001
) (
    input  gf_t a,
    output gf_t y
);

    always_comb begin
        y = gf_mul_c(a, C);
    end

endmodule

// File: rtl/chien_search_stage.sv
// Iterative Chien search for BCH(15,7) t=2: one codeword position per clock.
// Optional CHIEN_CORRECT_EN adds cw_in/cw_out and applies the error mask.
module chien_search_stage
    import bch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  l1,
    input  logic [3:0]  l2,
`ifdef CHIEN_CORRECT_EN
    input  logic [14:0] cw_in,
    output logic [14:0] cw_out,
`endif
    output logic        out_valid,
    output logic [14:0] err_mask,
    output logic [1:0]  err_cnt,
    output logic        fail
);

    chien_state_t state;
    chien_state_t nstate;

    logic        ld;
    logic        step;
    logic        fin;

    gf_t         r1;
    gf_t         r2;
    gf_t         r1n;
    gf_t         r2n;
    gf_t         ev;
    logic [3:0]  j;
    logic [1:0]  deg;
    logic [14:0] acc_mask;
    logic [1:0]  acc_cnt;
    logic        fail_n;

`ifdef CHIEN_CORRECT_EN
    logic [14:0] cw_in_q;
`endif

    gf_mul_const #(.C(ALPHA_INV))  u_mul1 (.a(r1), .y(r1n));
    gf_mul_const #(.C(ALPHA_INV2)) u_mul2 (.a(r2), .y(r2n));

    // sigma(alpha^-j) with r1/r2 already scaled to position j
    assign ev     = 4'b0001 ^ r1 ^ r2;
    assign fail_n = (acc_cnt != deg) | (acc_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (in_valid) nstate = SEARCH;
            SEARCH:  if (j == 4'(N - 1)) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        ld       = 1'b0;
        step     = 1'b0;
        fin      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                ld       = in_valid;
            end
            SEARCH:  step = 1'b1;
            DONE:    fin  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1        <= '0;
            r2        <= '0;
            j         <= '0;
            deg       <= '0;
            acc_mask  <= '0;
            acc_cnt   <= '0;
            out_valid <= 1'b0;
            err_mask  <= '0;
            err_cnt   <= '0;
            fail      <= 1'b0;
        end else begin
            out_valid <= fin;
            if (ld) begin
                r1       <= l1;
                r2       <= l2;
                j        <= '0;
                deg      <= (l2 != '0) ? 2'd2 : (l1 != '0) ? 2'd1 : 2'd0;
                acc_mask <= '0;
                acc_cnt  <= '0;
            end
            if (step) begin
                if (ev == '0) begin
                    acc_mask <= acc_mask | (15'd1 << j);
                    if (acc_cnt != 2'd3) acc_cnt <= acc_cnt + 2'd1;
                end
                r1 <= r1n;
                r2 <= r2n;
                j  <= j + 4'd1;
            end
            if (fin) begin
                err_mask <= acc_mask;
                err_cnt  <= acc_cnt;
                fail     <= fail_n;
            end
        end
    end

`ifdef CHIEN_CORRECT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cw_in_q <= '0;
            cw_out  <= '0;
        end else begin
            if (ld) cw_in_q <= cw_in;
            if (fin) cw_out <= fail_n ? cw_in_q : (cw_in_q ^ acc_mask);
        end
    end
`endif

endmodule
